// File: rtl/display_pkg.sv
// Shared constants, state encoding and slice/anode helpers for the 4-digit scan display.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 7;
   localparam int SEG_BUS_W  = 28;

   localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'hF;

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   typedef logic [1:0] digit_idx_t;

   function automatic logic [SEG_W-1:0] seg_slice(input logic [SEG_BUS_W-1:0] bus,
                                                  input digit_idx_t idx);
      return bus[SEG_W*int'(idx) +: SEG_W];
   endfunction

   function automatic logic [NUM_DIGITS-1:0] anode_for(input digit_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Scan controller control/data bundle: enable, segment bus and lamp mask in, drive lines out.
interface display_scan_controller_if;
   import display_pkg::*;

   logic                  enable_in;
   logic [SEG_BUS_W-1:0]  seg_bus_in;
   logic [NUM_DIGITS-1:0] digit_en_in;
   logic [NUM_DIGITS-1:0] anode_out;
   logic [SEG_W-1:0]      seg_out;
   logic                  frame_done_out;

   modport master (
      output enable_in, seg_bus_in, digit_en_in,
      input  anode_out, seg_out, frame_done_out
   );

   modport slave (
      input  enable_in, seg_bus_in, digit_en_in,
      output anode_out, seg_out, frame_done_out
   );

endinterface

// File: rtl/scan_phase_timer.sv
// Phase tick counter; flags the terminal count of the current BLANK or SHOW phase.
module scan_phase_timer #(
   parameter int SHOW_TICKS  = 99_000,
   parameter int BLANK_TICKS = 1_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic show_phase,
   output logic last
);

   localparam int MAX_TICKS = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
   localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

   localparam logic [CNT_W-1:0] SHOW_END  = CNT_W'(SHOW_TICKS - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_TICKS - 1);

   logic [CNT_W-1:0] cnt_r;

   assign last = (cnt_r == (show_phase ? SHOW_END : BLANK_END));

   // Count within the phase; restart at terminal count or when the scan is parked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clear || last) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes a packed 4-digit segment bus onto active-low anodes with per-slot blanking.
module display_scan_controller
   import display_pkg::*;
#(
   parameter int SHOW_TICKS  = 99_000,
   parameter int BLANK_TICKS = 1_000
) (
   input logic                      clk_in,
   input logic                      reset_in,
   display_scan_controller_if.slave scan
);

   logic [0:0]            state_r, state_s;
   digit_idx_t            idx_r, idx_s;
   logic                  parked_r, parked_s;
   logic [SEG_BUS_W-1:0]  snap_r, snap_s;
   logic                  frame_done_s;
   logic [NUM_DIGITS-1:0] anode_r, anode_s;
   logic [SEG_W-1:0]      seg_r, seg_s;
   logic                  frame_done_r;
   logic                  phase_last_s;
   logic                  timer_clear_s;

   // Parked covers both enable low and the one restart cycle after enable returns.
   assign timer_clear_s = !scan.enable_in || parked_r;

   scan_phase_timer #(
      .SHOW_TICKS  (SHOW_TICKS),
      .BLANK_TICKS (BLANK_TICKS)
   ) u_timer (
      .clk        (clk_in),
      .rst        (reset_in),
      .clear      (timer_clear_s),
      .show_phase (state_r == ST_SHOW),
      .last       (phase_last_s)
   );

   // Next scan state, digit, snapshot and frame pulse.
   always_comb begin
      state_s      = state_r;
      idx_s        = idx_r;
      parked_s     = parked_r;
      snap_s       = snap_r;
      frame_done_s = 1'b0;
      if (!scan.enable_in) begin
         state_s  = ST_BLANK;
         idx_s    = 2'd0;
         parked_s = 1'b1;
      end else if (parked_r) begin
         parked_s = 1'b0;
      end else if (phase_last_s) begin
         case (state_r)
            ST_BLANK: begin
               state_s = ST_SHOW;
               // Latch the whole bus once per frame so a mid-scan update cannot tear.
               if (idx_r == 2'd0) begin
                  snap_s = scan.seg_bus_in;
               end else begin
                  snap_s = snap_r;
               end
            end
            ST_SHOW: begin
               state_s      = ST_BLANK;
               idx_s        = idx_r + 2'd1;
               frame_done_s = (idx_r == 2'd3);
            end
            default: begin
               state_s = ST_BLANK;
               idx_s   = 2'd0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Drive values for the upcoming cycle; the lamp mask is applied live.
   always_comb begin
      anode_s = ANODE_OFF;
      seg_s   = SEG_BLANK;
      if ((state_s == ST_SHOW) && scan.digit_en_in[idx_s]) begin
         anode_s = anode_for(idx_s);
         seg_s   = seg_slice(snap_s, idx_s);
      end else begin
         anode_s = ANODE_OFF;
         seg_s   = SEG_BLANK;
      end
   end

   // State and registered outputs; reset darkens the display immediately.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_r      <= ST_BLANK;
         idx_r        <= 2'd0;
         parked_r     <= 1'b0;
         snap_r       <= 28'h0;
         anode_r      <= ANODE_OFF;
         seg_r        <= SEG_BLANK;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         idx_r        <= idx_s;
         parked_r     <= parked_s;
         snap_r       <= snap_s;
         anode_r      <= anode_s;
         seg_r        <= seg_s;
         frame_done_r <= frame_done_s;
      end
   end

   assign scan.anode_out      = anode_r;
   assign scan.seg_out        = seg_r;
   assign scan.frame_done_out = frame_done_r;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a frame-position reference model.
module tb_display_scan_controller;

   localparam int SHOW  = 4;
   localparam int BLANK = 2;
   localparam int SLOT  = SHOW + BLANK;
   localparam int FRAME = 4 * SLOT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   display_scan_controller_if ifc();

   display_scan_controller #(
      .SHOW_TICKS  (SHOW),
      .BLANK_TICKS (BLANK)
   ) dut (
      .clk_in   (clk),
      .reset_in (rst),
      .scan     (ifc)
   );

   always #5 clk = ~clk;

   // Reference model: position within the 24-cycle frame plus a per-frame snapshot.
   int          m_t;
   logic        m_parked;
   logic [27:0] m_snap;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_fd;

   always @(posedge clk or posedge rst) begin : model
      int          nt;
      logic        np;
      logic [27:0] ns;
      logic        nfd;
      int          slot;
      int          ph;
      if (rst) begin
         m_t      <= 0;
         m_parked <= 1'b0;
         m_snap   <= 28'h0;
         exp_an   <= 4'hF;
         exp_seg  <= 7'h7F;
         exp_fd   <= 1'b0;
      end else begin
         nt  = m_t;
         np  = m_parked;
         ns  = m_snap;
         nfd = 1'b0;
         if (!ifc.enable_in) begin
            np = 1'b1;
            nt = 0;
         end else if (m_parked) begin
            np = 1'b0;
            nt = 0;
         end else begin
            if (m_t == BLANK - 1) ns = ifc.seg_bus_in;
            if (m_t == FRAME - 1) begin
               nt  = 0;
               nfd = 1'b1;
            end else begin
               nt = m_t + 1;
            end
         end
         slot = nt / SLOT;
         ph   = nt % SLOT;
         m_t      <= nt;
         m_parked <= np;
         m_snap   <= ns;
         exp_fd   <= nfd;
         if (!np && ph >= BLANK && ifc.digit_en_in[slot]) begin
            exp_an  <= 4'hF & ~(4'd1 << slot);
            exp_seg <= 7'((ns >> (7 * slot)) & 28'h7F);
         end else begin
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checks++;
      if (ifc.anode_out !== exp_an || ifc.seg_out !== exp_seg || ifc.frame_done_out !== exp_fd) begin
         errors++;
         $display("FAIL model t=%0t cyc=%0d got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                  $time, cyc, ifc.anode_out, ifc.seg_out, ifc.frame_done_out,
                  exp_an, exp_seg, exp_fd);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
      end
   endtask

   task automatic adv_to(input int k);
      while (cyc < k) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      ifc.enable_in   = 1'b0;
      ifc.seg_bus_in  = 28'h0;
      ifc.digit_en_in = 4'hF;
      repeat (2) @(negedge clk);
      chk("reset_anode", 32'(ifc.anode_out), 32'hF);
      chk("reset_seg", 32'(ifc.seg_out), 32'h7F);
      chk("reset_fd", 32'(ifc.frame_done_out), 32'h0);

      // Nominal scan, tearing and wrap.
      rst = 1'b0;
      ifc.enable_in  = 1'b1;
      ifc.seg_bus_in = 28'h0ABCDEF;
      cyc = 0;
      adv_to(1);  chk("blank0_anode", 32'(ifc.anode_out), 32'hF);
      adv_to(2);  chk("d0_anode", 32'(ifc.anode_out), 32'hE);
                  chk("d0_seg", 32'(ifc.seg_out), 32'h6F);
      adv_to(8);  chk("d1_anode", 32'(ifc.anode_out), 32'hD);
                  chk("d1_seg", 32'(ifc.seg_out), 32'h1B);
      adv_to(9);  ifc.seg_bus_in = 28'h1234567;
      adv_to(14); chk("d2_anode", 32'(ifc.anode_out), 32'hB);
                  chk("d2_seg_old", 32'(ifc.seg_out), 32'h2F);
      adv_to(20); chk("d3_anode", 32'(ifc.anode_out), 32'h7);
                  chk("d3_seg_old", 32'(ifc.seg_out), 32'h05);
      adv_to(23); chk("fd_early", 32'(ifc.frame_done_out), 32'h0);
      adv_to(24); chk("fd_24", 32'(ifc.frame_done_out), 32'h1);
      adv_to(25); chk("fd_width", 32'(ifc.frame_done_out), 32'h0);
      adv_to(26); chk("d0_seg_new", 32'(ifc.seg_out), 32'h67);
      adv_to(32); chk("d1_seg_new", 32'(ifc.seg_out), 32'h0A);
      adv_to(48); chk("fd_48", 32'(ifc.frame_done_out), 32'h1);
      adv_to(72); chk("fd_72", 32'(ifc.frame_done_out), 32'h1);

      // Lamp mask 0101.
      ifc.digit_en_in = 4'b0101;
      adv_to(74); chk("mask_d0", 32'(ifc.anode_out), 32'hE);
      adv_to(80); chk("mask_d1_dark", 32'(ifc.anode_out), 32'hF);
      adv_to(86); chk("mask_d2", 32'(ifc.anode_out), 32'hB);
                  chk("mask_d2_seg", 32'(ifc.seg_out), 32'h0D);
      adv_to(92); chk("mask_d3_dark", 32'(ifc.anode_out), 32'hF);
      adv_to(96); chk("mask_fd_96", 32'(ifc.frame_done_out), 32'h1);
      ifc.digit_en_in = 4'hF;

      // Enable abort during digit 2 and restart with a fresh snapshot.
      adv_to(100); ifc.seg_bus_in = 28'h0ABCDEF;
      adv_to(111); ifc.enable_in = 1'b0;
      adv_to(112); chk("abort_dark", 32'(ifc.anode_out), 32'hF);
      adv_to(120); chk("abort_no_fd", 32'(ifc.frame_done_out), 32'h0);
      adv_to(126); ifc.enable_in = 1'b1;
      adv_to(128); chk("restart_blank", 32'(ifc.anode_out), 32'hF);
      adv_to(129); chk("restart_d0", 32'(ifc.anode_out), 32'hE);
                   chk("restart_seg", 32'(ifc.seg_out), 32'h6F);
      adv_to(150); chk("restart_fd_early", 32'(ifc.frame_done_out), 32'h0);
      adv_to(151); chk("restart_fd", 32'(ifc.frame_done_out), 32'h1);

      // Asynchronous reset while digit 3 is lit.
      adv_to(172); chk("pre_rst_d3", 32'(ifc.anode_out), 32'h7);
      #2 rst = 1'b1;
      #1;
      chk("async_anode", 32'(ifc.anode_out), 32'hF);
      chk("async_seg", 32'(ifc.seg_out), 32'h7F);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      adv_to(2);  chk("post_rst_d0", 32'(ifc.anode_out), 32'hE);
                  chk("post_rst_seg", 32'(ifc.seg_out), 32'h6F);
      adv_to(24); chk("post_rst_fd", 32'(ifc.frame_done_out), 32'h1);
      adv_to(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
